mux_rr_sequencer: RTL and testbench

//   Upstream control stage for the 4-to-1 4-bit channel mux (mx4to1). Arbitrates four

---
 rtl/mux_seq_pkg.sv | 22 ++
 rtl/mux_rr_sequencer_rr_pick.sv | 47 ++++
 rtl/mux_rr_sequencer.sv | 109 ++++++++++
 tb/tb_mux_rr_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mux_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mux_seq_pkg
// Brief   : Shared constants, state type and helpers for mux_rr_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package mux_seq_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = $clog2(NCH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } seq_state_t;

    function automatic logic [NCH-1:0] sel_onehot(input logic [SEL_W-1:0] s);
        return NCH'(1) << s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_rr_sequencer_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational next-channel picker. Round-robin from last+1 by
//           default; lowest index wins when MUX_SEQ_FIXED_PRIO_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick
    import mux_seq_pkg::*;
(
    input  logic [NCH-1:0]   req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [SEL_W-1:0] w_idx;

`ifdef MUX_SEQ_FIXED_PRIO_EN
    logic w_unused_last;
    assign w_unused_last = ^last;

    always_comb begin
        w_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) w_idx = SEL_W'(i);
        end
    end
`else
    logic [SEL_W-1:0] w_ch;

    // Scan farthest-first so the nearest channel after last wins.
    always_comb begin
        w_idx = '0;
        w_ch  = '0;
        for (int i = NCH; i >= 1; i--) begin
            w_ch = SEL_W'(int'(last) + i);
            if (req[w_ch]) w_idx = w_ch;
        end
    end
`endif

    assign idx = w_idx;
    assign any = |req;

endmodule
`default_nettype wire

// File: rtl/mux_rr_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : mux_rr_sequencer
// Brief   : Round-robin request sequencer driving sel/en of a 4:1 mux; each
//           grant dwells DWELL cycles and ends with a one-cycle ack pulse.
//           Option macro: MUX_SEQ_FIXED_PRIO_EN (fixed priority, ch0 highest).
// Revision: 1.0 - initial release
// ============================================================================
module mux_rr_sequencer
    import mux_seq_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   req,
    output logic [SEL_W-1:0] sel,
    output logic             en,
    output logic [NCH-1:0]   ack,
    output logic             busy
);

    localparam logic [7:0] c_last_cnt  = 8'(DWELL - 1);
    localparam bit         c_dwell_one = (DWELL == 1);

    seq_state_t       r_state;
    logic [7:0]       r_cnt;
    logic [SEL_W-1:0] r_last;
    logic [SEL_W-1:0] r_sel;
    logic             r_en;
    logic [NCH-1:0]   r_ack;
    logic             r_busy;

    logic [SEL_W-1:0] w_pick_last;
    logic [SEL_W-1:0] w_idx;
    logic             w_any;
    logic             w_done;
    logic             w_abort;
    logic [7:0]       w_cnt_nxt;

    // While granting, the pointer is about to become the current channel.
    assign w_pick_last = (r_state == GRANT) ? r_sel : r_last;
    assign w_done      = (r_cnt == c_last_cnt);
    assign w_abort     = !req[r_sel] && !w_done;
    assign w_cnt_nxt   = r_cnt + 8'd1;

    rr_pick u_rr_pick (
        .req  (req),
        .last (w_pick_last),
        .idx  (w_idx),
        .any  (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= SEL_W'(NCH - 1);
            r_sel   <= '0;
            r_en    <= 1'b0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_ack <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= GRANT;
                        r_sel   <= w_idx;
                        r_en    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        if (c_dwell_one) r_ack <= sel_onehot(w_idx);
                    end
                end
                GRANT: begin
                    if (w_done || w_abort) begin
                        r_last <= r_sel;
                        if (w_any) begin
                            r_sel <= w_idx;
                            r_cnt <= '0;
                            if (c_dwell_one) r_ack <= sel_onehot(w_idx);
                        end else begin
                            r_state <= IDLE;
                            r_en    <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        // ack is registered, so raise it entering the final cycle.
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt == c_last_cnt) r_ack <= sel_onehot(r_sel);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sel  = r_sel;
    assign en   = r_en;
    assign ack  = r_ack;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_mux_rr_sequencer
// Brief   : Directed self-checking bench: DWELL=4 and DWELL=1 instances.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mux_rr_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req4 = '0;
    logic [3:0] req1 = '0;

    logic [1:0] sel4, sel1;
    logic       en4, en1, busy4, busy1;
    logic [3:0] ack4, ack1;
    logic [3:0] w_mux_out;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    mux_rr_sequencer #(.DWELL(4)) u_dut4 (
        .clk (clk), .rst (rst), .req (req4),
        .sel (sel4), .en (en4), .ack (ack4), .busy (busy4)
    );

    mux_rr_sequencer #(.DWELL(1)) u_dut1 (
        .clk (clk), .rst (rst), .req (req1),
        .sel (sel1), .en (en1), .ack (ack1), .busy (busy1)
    );

    // Stand-in for mx4to1 with a=1, b=2, c=4, d=8.
    assign w_mux_out = en4 ? (4'b0001 << sel4) : 4'b0000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string tag, input logic [1:0] s, input logic e, input logic [3:0] a);
        chk({tag, ".sel"}, 32'(sel4), 32'(s));
        chk({tag, ".en"}, 32'(en4), 32'(e));
        chk({tag, ".busy"}, 32'(busy4), 32'(e));
        chk({tag, ".ack"}, 32'(ack4), 32'(a));
    endtask

    initial begin
        logic [1:0] s_exp;

        // Reset held with all requests pending
        rst  = 1'b1;
        req4 = 4'b1111;
        tick();
        tick();
        chk4("reset", 2'd0, 1'b0, 4'b0000);

        // Round-robin over all four channels, no bubbles
        rst = 1'b0;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                s_exp = 2'(g % 4);
                chk4($sformatf("rr.g%0d.c%0d", g, c), s_exp, 1'b1,
                     (c == 3) ? (4'b0001 << s_exp) : 4'b0000);
                if (g == 0 && c == 0) chk("mux_out", 32'(w_mux_out), 32'h1);
            end
        end

        // Back to idle
        rst  = 1'b1;
        req4 = 4'b0000;
        tick();
        rst = 1'b0;
        tick();
        chk4("idle", 2'd0, 1'b0, 4'b0000);

        // Single request on ch2, released on its ack cycle
        req4 = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk4($sformatf("single.c%0d", c), 2'd2, 1'b1, (c == 3) ? 4'b0100 : 4'b0000);
        end
        req4 = 4'b0000;
        tick();
        chk4("single.end", 2'd2, 1'b0, 4'b0000);

        // Abort ch1 with nothing pending -> idle, no ack
        req4 = 4'b0010;
        tick();
        chk4("abort1.c0", 2'd1, 1'b1, 4'b0000);
        tick();
        chk4("abort1.c1", 2'd1, 1'b1, 4'b0000);
        req4 = 4'b0000;
        tick();
        chk4("abort1.end", 2'd1, 1'b0, 4'b0000);

        // Abort ch1 with ch3 pending -> straight to ch3
        req4 = 4'b0010;
        tick();
        chk4("abort2.c0", 2'd1, 1'b1, 4'b0000);
        tick();
        chk4("abort2.c1", 2'd1, 1'b1, 4'b0000);
        req4 = 4'b1000;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk4($sformatf("abort2.ch3.c%0d", c), 2'd3, 1'b1, (c == 3) ? 4'b1000 : 4'b0000);
        end
        req4 = 4'b0000;
        tick();
        chk4("abort2.end", 2'd3, 1'b0, 4'b0000);

        // Reset during ch2 grant at cnt=2
        req4 = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk4($sformatf("rstmid.c%0d", c), 2'd2, 1'b1, 4'b0000);
        end
        rst = 1'b1;
        tick();
        chk4("rstmid.rst", 2'd0, 1'b0, 4'b0000);
        rst  = 1'b0;
        req4 = 4'b0000;
        tick();
        chk4("rstmid.after", 2'd0, 1'b0, 4'b0000);

        // DWELL=1 with ch1 and ch3 requesting
        req1 = 4'b1010;
        for (int c = 0; c < 6; c++) begin
            tick();
`ifdef MUX_SEQ_FIXED_PRIO_EN
            s_exp = 2'd1;
`else
            s_exp = (c % 2 == 0) ? 2'd1 : 2'd3;
`endif
            chk($sformatf("dw1.c%0d.sel", c), 32'(sel1), 32'(s_exp));
            chk($sformatf("dw1.c%0d.en", c), 32'(en1), 32'd1);
            chk($sformatf("dw1.c%0d.ack", c), 32'(ack1), 32'(4'b0001 << s_exp));
        end
        req1 = 4'b0000;
        tick();
        chk("dw1.end.en", 32'(en1), 32'd0);
        chk("dw1.end.ack", 32'(ack1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
